timer_sequencer: RTL and testbench
==================================

Name: timer_sequencer

Overview:
- Queues timed-delay requests from a master and runs them one at a time on a single Timer peripheral (ctrl/preset/count registers at word offsets 0/1/2).
- Drives the Timer register port directly: stop, load preset, start with IRQ enabled, wait for IRQ, acknowledge.
- Returns a one-cycle completion pulse carrying the request tag.
- Sits between the CPU-side bridge (or DMA/scheduler software proxy) and the Timer instance.

Parameters:
DEPTH, 4, request FIFO entries (power of 2, ≥2)
TAG_W, 4, request tag width
BASE, 32'h0000_7F00, Timer byte base address (word aligned)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = reset)
req_valid  input  1  request offered
req_ready  output  1  request accepted when req_valid&&req_ready at posedge
req_delay  input  32  preset value to load
req_tag  input  TAG_W  request identifier
abort  input  1  synchronous flush of queue and in-flight request
tim_addr  output  30  Timer word address [31:2]
tim_we  output  1  Timer write enable
tim_din  output  32  Timer write data
tim_dout  input  32  Timer read data
tim_irq  input  1  Timer IRQ
done_valid  output  1  one-cycle completion pulse
done_tag  output  TAG_W  tag of completed request (valid with done_valid)
remain  output  32  tim_dout while in WAIT, else 0
busy  output  1  state != IDLE
pending  output  log2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, reset==0): state=IDLE, FIFO empty, pending=0, tim_we=0, tim_addr=BASE[31:2], tim_din=0, done_valid=0, done_tag=0, busy=0, remain=0. Reset mid-operation abandons everything. Timer is reset by the same system reset.
- FIFO: req_ready = !full && !abort. No bypass: a request pushed into an empty FIFO is popped no earlier than the next edge.
- Simultaneous push and pop: both happen, so pending is unchanged. Full FIFO: req_ready=0 and the request is held off.
- Outputs are Moore, decoded from state and current registers. tim_we=0 unless stated otherwise.
- States:
  - IDLE: tim_addr=BASE+0. If FIFO not empty, pop head into cur_delay/cur_tag and go to W_STOP.
  - W_STOP: tim_we=1, addr=ctrl(BASE+0), din=0. Go to W_PRESET.
  - W_PRESET: tim_we=1, addr=preset(BASE+4), din=cur_delay. Go to W_START.
  - W_START: tim_we=1, addr=ctrl, din=32'h9 (IM=1, mode 00, enable). Go to WAIT.
  - WAIT: addr=count(BASE+8), remain=tim_dout. If tim_irq, go to DONE.
  - DONE: tim_we=1, addr=ctrl, din=0 (clears IM, dropping IRQ); done_valid=1, done_tag=cur_tag. Go to IDLE.
  - ABRT: tim_we=1, addr=ctrl, din=0. Go to IDLE. No done pulse.
- abort=1 at an edge:
  - FIFO is flushed and any same-cycle push is dropped.
  - From W_STOP/W_PRESET/W_START/WAIT: go to ABRT.
  - From DONE: the done pulse still completes, then go to IDLE.
  - From IDLE: flush only; no pop occurs that cycle.
- abort has priority over tim_irq in WAIT.
- Latency, with Timer idle and request accepted at edge E, preset N≥1: Timer IRQ rises after edge E+6+N; done_valid is high for exactly the cycle following edge E+7+N. N=0 behaves as N=1.
- Back-to-back requests: the next pop occurs in the IDLE cycle right after DONE. Minimum 5 cycles of sequencer overhead per request.
- tim_irq outside WAIT is ignored.
- remain width 32, no arithmetic. pending counts 0..DEPTH; pointers wrap modulo DEPTH.

Test Plan:
- Reset: hold reset=0 mid-WAIT, release → all outputs at reset values, pending=0. Timer ctrl is 0 after its own reset.
- Single request: delay=5, tag=3 accepted at E → write sequence ctrl=0, preset=5, ctrl=9 on edges E+2..E+4; done_valid=1 with done_tag=3 exactly after edge E+12; IRQ low after DONE.
- Queue full: push tags 1..4 (delay=2) then a 5th → req_ready=0 on the 5th and pending=4. Completions arrive in order 1,2,3,4, each in a separate done pulse; pending returns to 0.
- Simultaneous push/pop: push at the same edge IDLE pops → pending unchanged, FIFO order preserved.
- Abort in WAIT with delay=100 and 2 queued: abort=1 for one cycle → ABRT writes ctrl=0, no done pulse, pending=0, busy=0 two edges later. remain froze below 100 before abort.
- Abort during push and during DONE: push dropped (req_ready=0). A DONE in progress still emits its pulse; FIFO is empty afterwards.

Source files
------------

// File: rtl/timer_sequencer_if.sv
// Request/completion side and Timer register port of the timer sequencer.
// The slave modport is the sequencer. The master modport is its environment: the requester and the Timer.
interface timer_sequencer_if #(
    parameter int TAG_W  = 4,
    parameter int PEND_W = 3
);
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_delay;
    logic [TAG_W-1:0]  req_tag;
    logic              abort;
    logic [29:0]       tim_addr;
    logic              tim_we;
    logic [31:0]       tim_din;
    logic [31:0]       tim_dout;
    logic              tim_irq;
    logic              done_valid;
    logic [TAG_W-1:0]  done_tag;
    logic [31:0]       remain;
    logic              busy;
    logic [PEND_W-1:0] pending;

    modport master (
        output req_valid, req_delay, req_tag, abort, tim_dout, tim_irq,
        input  req_ready, tim_addr, tim_we, tim_din, done_valid, done_tag,
               remain, busy, pending
    );

    modport slave (
        input  req_valid, req_delay, req_tag, abort, tim_dout, tim_irq,
        output req_ready, tim_addr, tim_we, tim_din, done_valid, done_tag,
               remain, busy, pending
    );
endinterface

// File: rtl/timer_sequencer.sv
// Queues delay requests and runs each one on a single Timer peripheral.
// Each request does stop, load preset, start with IRQ, wait for IRQ, then acknowledge.
module timer_sequencer #(
    parameter int          DEPTH = 4,
    parameter int          TAG_W = 4,
    parameter logic [31:0] BASE  = 32'h0000_7F00
) (
    input  logic            clk,
    input  logic            reset,
    timer_sequencer_if.slave bus
);
    localparam int          PTR_W      = $clog2(DEPTH);
    localparam int          CNT_W      = PTR_W + 1;
    localparam logic [29:0] A_CTRL     = BASE[31:2];
    localparam logic [29:0] A_PRESET   = BASE[31:2] + 30'd1;
    localparam logic [29:0] A_COUNT    = BASE[31:2] + 30'd2;
    localparam logic [31:0] CTRL_START = 32'h0000_0009;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_STOP,
        S_W_PRESET,
        S_W_START,
        S_WAIT,
        S_DONE,
        S_ABRT
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [31:0]      r_mem_delay [DEPTH];
    logic [TAG_W-1:0] r_mem_tag   [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_cur_delay;
    logic [TAG_W-1:0] r_cur_tag;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    logic [29:0]      w_tim_addr;
    logic             w_tim_we;
    logic [31:0]      w_tim_din;
    logic             w_done_valid;
    logic [TAG_W-1:0] w_done_tag;
    logic [31:0]      w_remain;

    assign w_full        = (r_count == CNT_W'(DEPTH));
    assign w_empty       = (r_count == '0);
    assign bus.req_ready = !w_full && !bus.abort;
    assign w_push        = bus.req_valid && bus.req_ready;
    // The pop looks at the registered count, so a request pushed into an empty FIFO waits one edge.
    assign w_pop         = (r_state == S_IDLE) && !w_empty && !bus.abort;

    // NOTE: the storage array is not reset. Only the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_delay[r_wr_ptr] <= bus.req_delay;
            r_mem_tag[r_wr_ptr]   <= bus.req_tag;
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cur_delay <= '0;
            r_cur_tag   <= '0;
        end else if (w_pop) begin
            r_cur_delay <= r_mem_delay[r_rd_ptr];
            r_cur_tag   <= r_mem_tag[r_rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_pop) w_next = S_W_STOP;
            S_W_STOP:   w_next = bus.abort ? S_ABRT : S_W_PRESET;
            S_W_PRESET: w_next = bus.abort ? S_ABRT : S_W_START;
            S_W_START:  w_next = bus.abort ? S_ABRT : S_WAIT;
            S_WAIT: begin
                if (bus.abort)        w_next = S_ABRT;
                else if (bus.tim_irq) w_next = S_DONE;
            end
            S_DONE:     w_next = S_IDLE;
            S_ABRT:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_tim_addr   = A_CTRL;
        w_tim_we     = 1'b0;
        w_tim_din    = '0;
        w_done_valid = 1'b0;
        w_done_tag   = '0;
        w_remain     = '0;
        case (r_state)
            S_W_STOP: w_tim_we = 1'b1;
            S_W_PRESET: begin
                w_tim_we   = 1'b1;
                w_tim_addr = A_PRESET;
                w_tim_din  = r_cur_delay;
            end
            S_W_START: begin
                w_tim_we  = 1'b1;
                w_tim_din = CTRL_START;
            end
            S_WAIT: begin
                w_tim_addr = A_COUNT;
                w_remain   = bus.tim_dout;
            end
            // Writing ctrl=0 clears IM, which drops the Timer IRQ before the next request starts.
            S_DONE: begin
                w_tim_we     = 1'b1;
                w_done_valid = 1'b1;
                w_done_tag   = r_cur_tag;
            end
            S_ABRT:  w_tim_we = 1'b1;
            default: ;
        endcase
    end

    assign bus.tim_addr   = w_tim_addr;
    assign bus.tim_we     = w_tim_we;
    assign bus.tim_din    = w_tim_din;
    assign bus.done_valid = w_done_valid;
    assign bus.done_tag   = w_done_tag;
    assign bus.remain     = w_remain;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.pending    = r_count;
endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench for timer_sequencer, with a small behavioural Timer model.
// It logs every Timer write and every done pulse by edge number and checks them against hand-computed timing.
module tb_timer_sequencer;
    localparam logic [31:0] BASE     = 32'h0000_7F00;
    localparam logic [29:0] A_CTRL   = BASE[31:2];
    localparam logic [29:0] A_PRESET = BASE[31:2] + 30'd1;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;

    timer_sequencer_if #(.TAG_W(4), .PEND_W(3)) bus ();

    timer_sequencer #(.DEPTH(4), .TAG_W(4), .BASE(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timer model: a ctrl write arms the Timer, the next edge loads max(preset,1), and it counts down to 0.
    // The edge after the count reaches 0 raises the IRQ if IM is set.
    logic [31:0] t_ctrl, t_preset, t_count;
    logic        t_arm, t_run, t_irq;
    logic [29:0] t_off;
    assign t_off        = bus.tim_addr - A_CTRL;
    assign bus.tim_irq  = t_irq;
    assign bus.tim_dout = (t_off == 30'd2) ? t_count : (t_off == 30'd1) ? t_preset : t_ctrl;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            t_ctrl <= '0; t_preset <= '0; t_count <= '0;
            t_arm <= 1'b0; t_run <= 1'b0; t_irq <= 1'b0;
        end else if (bus.tim_we && t_off == 30'd0) begin
            t_ctrl <= bus.tim_din;
            t_arm  <= bus.tim_din[0];
            t_run  <= 1'b0;
            if (!bus.tim_din[3]) t_irq <= 1'b0;
        end else if (bus.tim_we && t_off == 30'd1) begin
            t_preset <= bus.tim_din;
        end else if (t_arm) begin
            t_arm   <= 1'b0;
            t_run   <= 1'b1;
            t_count <= (t_preset == 0) ? 32'd1 : t_preset;
        end else if (t_run) begin
            if (t_count != 0) t_count <= t_count - 32'd1;
            else begin
                t_run <= 1'b0;
                if (t_ctrl[3]) t_irq <= 1'b1;
            end
        end
    end

    typedef struct { int at; logic [29:0] addr; logic [31:0] data; } wr_t;
    typedef struct { int at; logic [3:0] tag; } done_t;
    wr_t   wr_q[$];
    done_t done_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset && bus.tim_we)
            wr_q.push_back('{at: cyc + 1, addr: bus.tim_addr, data: bus.tim_din});
    end

    always @(negedge clk) begin
        if (reset && bus.done_valid)
            done_q.push_back('{at: cyc, tag: bus.done_tag});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push1(input logic [31:0] d, input logic [3:0] t, output int e);
        bus.req_valid = 1'b1;
        bus.req_delay = d;
        bus.req_tag   = t;
        #1;
        check("push_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        e = cyc;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (done_q.size() < n && k < budget) begin
            step(1);
            k++;
        end
        check("done_timeout", 32'(done_q.size() >= n), 32'd1);
    endtask

    task automatic check_wr(input int idx, input int at, input logic [29:0] addr, input logic [31:0] data);
        if (idx >= wr_q.size()) begin
            check("wr_missing", 32'(idx), 32'(wr_q.size()));
        end else begin
            check("wr_at", 32'(wr_q[idx].at), 32'(at));
            check("wr_addr", 32'(wr_q[idx].addr), 32'(addr));
            check("wr_data", wr_q[idx].data, data);
        end
    endtask

    task automatic check_done(input int idx, input int at, input logic [3:0] tag);
        if (idx >= done_q.size()) begin
            check("done_missing", 32'(idx), 32'(done_q.size()));
        end else begin
            check("done_at", 32'(done_q[idx].at), 32'(at));
            check("done_tag", 32'(done_q[idx].tag), 32'(tag));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_pending"}, 32'(bus.pending), 32'd0);
        check({tag, "_we"}, 32'(bus.tim_we), 32'd0);
        check({tag, "_addr"}, 32'(bus.tim_addr), 32'(A_CTRL));
        check({tag, "_din"}, bus.tim_din, 32'd0);
        check({tag, "_done_valid"}, 32'(bus.done_valid), 32'd0);
        check({tag, "_done_tag"}, 32'(bus.done_tag), 32'd0);
        check({tag, "_remain"}, bus.remain, 32'd0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e, x, a;
        reset = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_delay = '0;
        bus.req_tag   = '0;
        bus.abort     = 1'b0;
        step(3);
        check_reset_outputs("rst");
        reset = 1'b1;
        step(2);

        // Single request, delay=5 tag=3.
        wr_q.delete(); done_q.delete();
        push1(32'd5, 4'd3, e);
        wait_done(1, 40);
        check("irq_after_done", 32'(bus.tim_irq), 32'd0);
        check("idle_after_done", 32'(bus.busy), 32'd0);
        check("wr_count", 32'(wr_q.size()), 32'd4);
        check_wr(0, e + 2, A_CTRL, 32'd0);
        check_wr(1, e + 3, A_PRESET, 32'd5);
        check_wr(2, e + 4, A_CTRL, 32'd9);
        check_wr(3, e + 13, A_CTRL, 32'd0);
        check_done(0, e + 12, 4'd3);

        // Preset 0 behaves as 1.
        done_q.delete();
        push1(32'd0, 4'd4, e);
        wait_done(1, 40);
        check_done(0, e + 8, 4'd4);
        step(2);

        // Fill the queue behind a long request, with a push coinciding with the IDLE pop.
        wr_q.delete(); done_q.delete();
        push1(32'd20, 4'd0, e);
        check("pend_first", 32'(bus.pending), 32'd1);
        push1(32'd2, 4'd1, x);
        check("pend_push_pop", 32'(bus.pending), 32'd1);
        push1(32'd2, 4'd2, x);
        push1(32'd2, 4'd3, x);
        push1(32'd2, 4'd4, x);
        check("pend_full", 32'(bus.pending), 32'd4);
        bus.req_valid = 1'b1;
        bus.req_delay = 32'd2;
        bus.req_tag   = 4'd5;
        #1;
        check("full_ready", 32'(bus.req_ready), 32'd0);
        step(1);
        check("full_pend_hold", 32'(bus.pending), 32'd4);
        bus.req_valid = 1'b0;
        wait_done(5, 200);
        check_done(0, e + 27, 4'd0);
        for (int i = 1; i < 5; i++)
            check_done(i, e + 27 + 10 * i, 4'(i));
        step(6);
        check("queue_drained", 32'(bus.pending), 32'd0);
        check("queue_idle", 32'(bus.busy), 32'd0);
        check("queue_no_extra", 32'(done_q.size()), 32'd5);

        // Abort while waiting on delay=100 with two requests queued.
        wr_q.delete(); done_q.delete();
        push1(32'd100, 4'd7, e);
        push1(32'd1, 4'd8, x);
        push1(32'd1, 4'd9, x);
        step(15);
        check("wait_busy", 32'(bus.busy), 32'd1);
        check("wait_pending", 32'(bus.pending), 32'd2);
        check("remain_below", 32'(bus.remain < 32'd100), 32'd1);
        check("remain_nonzero", 32'(bus.remain != 32'd0), 32'd1);
        bus.abort = 1'b1;
        #1;
        check("abort_ready", 32'(bus.req_ready), 32'd0);
        step(1);
        a = cyc;
        bus.abort = 1'b0;
        check("abort_flush", 32'(bus.pending), 32'd0);
        check("abrt_busy", 32'(bus.busy), 32'd1);
        step(1);
        check("abort_idle", 32'(bus.busy), 32'd0);
        check_wr(3, a + 1, A_CTRL, 32'd0);
        step(120);
        check("abort_no_done", 32'(done_q.size()), 32'd0);
        check("abort_irq", 32'(bus.tim_irq), 32'd0);
        check("abort_still_idle", 32'(bus.busy), 32'd0);

        // Abort in the same cycle as a push: the push is dropped.
        bus.req_valid = 1'b1;
        bus.req_delay = 32'd3;
        bus.req_tag   = 4'd10;
        bus.abort     = 1'b1;
        #1;
        check("abort_push_ready", 32'(bus.req_ready), 32'd0);
        step(1);
        bus.req_valid = 1'b0;
        bus.abort     = 1'b0;
        check("abort_push_pend", 32'(bus.pending), 32'd0);
        step(3);
        check("abort_push_idle", 32'(bus.busy), 32'd0);

        // Abort during DONE: the pulse completes and the queued request is flushed.
        wr_q.delete(); done_q.delete();
        push1(32'd1, 4'd5, e);
        push1(32'd1, 4'd6, x);
        while (cyc < e + 8) step(1);
        check("in_done", 32'(bus.done_valid), 32'd1);
        bus.abort = 1'b1;
        step(1);
        bus.abort = 1'b0;
        check("done_abort_pend", 32'(bus.pending), 32'd0);
        check("done_abort_idle", 32'(bus.busy), 32'd0);
        step(15);
        check("done_abort_count", 32'(done_q.size()), 32'd1);
        check_done(0, e + 8, 4'd5);
        check_wr(3, e + 9, A_CTRL, 32'd0);

        // Reset asserted mid-WAIT.
        push1(32'd50, 4'd2, e);
        step(10);
        check("pre_reset_busy", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        step(2);
        reset = 1'b1;
        step(1);
        check_reset_outputs("post_rst");
        check("post_rst_irq", 32'(bus.tim_irq), 32'd0);
        step(3);
        check("post_rst_idle", 32'(bus.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
